phase_sched: RTL and testbench
==============================

Name: phase_sched

Overview:
Instruction-phase sequencer for the cpu15 core.
- Replaces the free-running 4-phase rotation with a controlled FETCH -> DECODE -> EXECUTE -> WRITEBACK sequence.
- Supports run, single-step, stall and halt.
- Drives the per-phase enables consumed by the fetch, decode, execute and writeback logic.
- Counts retired instructions for debug and observation.

Parameters:
CNT_W, 16, width of the retired-instruction counter INSTR_CNT.

Ports:
CLK  in  1  system clock; all state updates on posedge CLK.
RST  in  1  synchronous, active-high reset.
RUN  in  1  level; 1 = execute instructions continuously.
STEP  in  1  pulse; in IDLE, executes exactly one instruction.
STALL  in  1  level; holds the current phase (memory or peripheral not ready).
HALT_IN  in  1  level from decode; current instruction is HALT, sampled in WB only.
PH_FT  out  1  fetch-phase enable.
PH_DC  out  1  decode-phase enable.
PH_EX  out  1  execute-phase enable.
PH_WB  out  1  writeback-phase enable.
BUSY  out  1  1 while in FT, DC, EX or WB.
HALTED  out  1  1 in HALT state.
INSTR_CNT  out  CNT_W  retired-instruction count.

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST), sampled on posedge CLK.
- Reset: state IDLE, step_mode 0; PH_* 0, BUSY 0, HALTED 0, INSTR_CNT 0. RST overrides all other inputs and applies mid-instruction; the partial instruction is abandoned and not counted.
- States: IDLE, FT, DC, EX, WB, HALT. All outputs are registered, decoded from state; PH_* are one-hot in FT/DC/EX/WB and all-zero in IDLE/HALT.
- IDLE transitions:
  - RUN=1 -> FT, step_mode=0.
  - else STEP=1 -> FT, step_mode=1.
  - else stay.
  - RUN and STEP both high: RUN wins.
  - Latency: RUN/STEP high at edge n -> PH_FT=1 after edge n.
- Phase advance: FT->DC->EX->WB, one cycle each when STALL=0.
  - STALL=1 in any phase: state holds and the same PH_* stays asserted.
  - No limit on stall length.
  - STALL is ignored in IDLE and HALT.
- Leaving WB (STALL=0):
  - INSTR_CNT += 1, modulo 2^CNT_W; all-ones wraps to 0.
  - HALT_IN=1 -> HALT.
  - else step_mode=1 or RUN=0 -> IDLE.
  - else -> FT (back-to-back, no bubble).
- WB with STALL=1: no count, HALT_IN not acted on until the stall releases.
- RUN deasserted mid-instruction: the instruction completes through WB, then IDLE.
- STEP during FT..WB: ignored, not queued.
- HALT: HALTED=1, BUSY=0. RUN, STEP and STALL are ignored; exit only via RST.
- Invalid state encoding: next state IDLE.

Decomposition:
- Shared include cpu15_defs.vh holds the state encoding localparams (IDLE, FT, DC, EX, WB, HALT; 3-bit) and the phase-index constants, so decode and debug logic can reference them.
- One natural sub-module, instr_counter: CNT_W-bit counter with sync clear and enable, where enable = WB & ~STALL.
- Everything else stays in phase_sched.

Test Plan:
1. Reset then RUN=1 held for 12 cycles, STALL=0:
   - PH_FT, PH_DC, PH_EX, PH_WB rotate one-hot starting the cycle after RUN is sampled.
   - INSTR_CNT=3 after 3 WBs.
   - Never two PH_* high together.
2. IDLE, single-cycle STEP pulse:
   - Exactly one FT, DC, EX, WB sequence, then IDLE with all PH_* 0.
   - INSTR_CNT increments by 1.
   - A second STEP pulse asserted during EX has no effect.
3. RUN=1 with STALL=1 for 3 cycles entering EX:
   - PH_EX high for 4 consecutive cycles, then WB.
   - INSTR_CNT still advances by exactly 1 for the instruction.
4. HALT_IN=1 in WB with STALL=1 for 2 cycles, then STALL=0:
   - HALT is entered only after the stall releases; HALTED=1, BUSY=0, INSTR_CNT +1.
   - Subsequent RUN=1 and STEP pulses leave HALTED=1.
   - RST returns to IDLE with INSTR_CNT=0.
5. CNT_W=4 and 17 instructions under RUN:
   - INSTR_CNT reads 15 then wraps to 0, then reads 1.
6. RST asserted during DC:
   - Next cycle: IDLE, PH_* 0, INSTR_CNT 0.
   - RUN=0 then RUN=1 restarts at FT.

Source files
------------

// File: rtl/phase_sched_pkg.sv
// Shared definitions for the cpu15 phase sequencer: state encoding, phase indices
// and the state-to-output decode used by both the sequencer and debug logic.
package phase_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FT   = 3'd1,
        ST_DC   = 3'd2,
        ST_EX   = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    localparam int PH_IDX_FT = 0;
    localparam int PH_IDX_DC = 1;
    localparam int PH_IDX_EX = 2;
    localparam int PH_IDX_WB = 3;

    typedef struct packed {
        logic ph_ft;
        logic ph_dc;
        logic ph_ex;
        logic ph_wb;
        logic busy;
        logic halted;
    } out_t;

    function automatic out_t decode_state(input state_e s);
        out_t o;
        o = '0;
        case (s)
            ST_FT:   begin o.ph_ft = 1'b1; o.busy = 1'b1; end
            ST_DC:   begin o.ph_dc = 1'b1; o.busy = 1'b1; end
            ST_EX:   begin o.ph_ex = 1'b1; o.busy = 1'b1; end
            ST_WB:   begin o.ph_wb = 1'b1; o.busy = 1'b1; end
            ST_HALT: o.halted = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/phase_sched_instr_counter.sv
// Retired-instruction counter: synchronous clear, increments by one per enabled
// cycle and wraps modulo 2^CNT_W. Count is visible the cycle after the enable.
module phase_sched_instr_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/phase_sched.sv
// Instruction-phase sequencer: FT->DC->EX->WB under run/step control, held by STALL,
// parked in HALT until reset. Outputs are registered; RUN/STEP at edge n gives PH_FT after n.
module phase_sched
    import phase_sched_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic             STEP,
    input  logic             STALL,
    input  logic             HALT_IN,
    output logic             PH_FT,
    output logic             PH_DC,
    output logic             PH_EX,
    output logic             PH_WB,
    output logic             BUSY,
    output logic             HALTED,
    output logic [CNT_W-1:0] INSTR_CNT
);

    state_e state_q;
    state_e state_d;
    logic   step_mode_q;
    logic   step_mode_d;
    out_t   out_q;
    logic   retire;

    always_comb begin
        state_d     = state_q;
        step_mode_d = step_mode_q;
        case (state_q)
            ST_IDLE: begin
                if (RUN) begin
                    state_d     = ST_FT;
                    step_mode_d = 1'b0;
                end else if (STEP) begin
                    state_d     = ST_FT;
                    step_mode_d = 1'b1;
                end
            end
            ST_FT: if (!STALL) state_d = ST_DC;
            ST_DC: if (!STALL) state_d = ST_EX;
            ST_EX: if (!STALL) state_d = ST_WB;
            ST_WB: begin
                // HALT_IN is only acted on once the writeback stall releases
                if (!STALL) begin
                    if (HALT_IN) begin
                        state_d = ST_HALT;
                    end else if (step_mode_q || !RUN) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FT;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            step_mode_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            step_mode_q <= step_mode_d;
            out_q       <= decode_state(state_d);
        end
    end

    assign retire = (state_q == ST_WB) && !STALL;

    phase_sched_instr_counter #(
        .CNT_W (CNT_W)
    ) u_instr_counter (
        .clk_i (CLK),
        .clr_i (RST),
        .en_i  (retire),
        .cnt_o (INSTR_CNT)
    );

    assign PH_FT  = out_q.ph_ft;
    assign PH_DC  = out_q.ph_dc;
    assign PH_EX  = out_q.ph_ex;
    assign PH_WB  = out_q.ph_wb;
    assign BUSY   = out_q.busy;
    assign HALTED = out_q.halted;

endmodule

// File: tb/tb_phase_sched.sv
// Directed bench for phase_sched: run, step, stall, halt, counter wrap and mid-instruction reset.
module tb_phase_sched;

    logic        CLK;
    logic        RST;
    logic        RUN;
    logic        STEP;
    logic        STALL;
    logic        HALT_IN;
    logic        PH_FT, PH_DC, PH_EX, PH_WB, BUSY, HALTED;
    logic [15:0] INSTR_CNT;
    logic        ph_ft4, ph_dc4, ph_ex4, ph_wb4, busy4, halted4;
    logic [3:0]  cnt4;

    int n_chk = 0;
    int n_bad = 0;

    // {PH_FT, PH_DC, PH_EX, PH_WB, BUSY, HALTED}
    localparam logic [5:0] O_IDLE = 6'b000000;
    localparam logic [5:0] O_FT   = 6'b100010;
    localparam logic [5:0] O_DC   = 6'b010010;
    localparam logic [5:0] O_EX   = 6'b001010;
    localparam logic [5:0] O_WB   = 6'b000110;
    localparam logic [5:0] O_HALT = 6'b000001;

    logic [5:0] obs;
    logic [5:0] obs4;
    assign obs  = {PH_FT, PH_DC, PH_EX, PH_WB, BUSY, HALTED};
    assign obs4 = {ph_ft4, ph_dc4, ph_ex4, ph_wb4, busy4, halted4};

    phase_sched #(.CNT_W(16)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .RUN       (RUN),
        .STEP      (STEP),
        .STALL     (STALL),
        .HALT_IN   (HALT_IN),
        .PH_FT     (PH_FT),
        .PH_DC     (PH_DC),
        .PH_EX     (PH_EX),
        .PH_WB     (PH_WB),
        .BUSY      (BUSY),
        .HALTED    (HALTED),
        .INSTR_CNT (INSTR_CNT)
    );

    phase_sched #(.CNT_W(4)) u_dut4 (
        .CLK       (CLK),
        .RST       (RST),
        .RUN       (RUN),
        .STEP      (STEP),
        .STALL     (STALL),
        .HALT_IN   (HALT_IN),
        .PH_FT     (ph_ft4),
        .PH_DC     (ph_dc4),
        .PH_EX     (ph_ex4),
        .PH_WB     (ph_wb4),
        .BUSY      (busy4),
        .HALTED    (halted4),
        .INSTR_CNT (cnt4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [5:0] exp_o, input int exp_cnt);
        chk({tag, ".out"}, 32'(obs), 32'(exp_o));
        chk({tag, ".cnt"}, 32'(INSTR_CNT), exp_cnt);
    endtask

    initial begin
        logic [5:0] rot [4];
        rot[0] = O_FT; rot[1] = O_DC; rot[2] = O_EX; rot[3] = O_WB;

        RST = 1'b1; RUN = 1'b0; STEP = 1'b0; STALL = 1'b0; HALT_IN = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        chk_st("reset", O_IDLE, 0);
        tick();
        chk_st("idle_hold", O_IDLE, 0);

        // 1: continuous run
        RUN = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk_st($sformatf("run_c%0d", k), rot[k % 4], k / 4);
        end
        RUN = 1'b0;
        tick();
        chk_st("run_stop", O_IDLE, 3);

        // 2: single step, second STEP during EX ignored
        STEP = 1'b1;
        tick();
        STEP = 1'b0;
        chk_st("step_ft", O_FT, 3);
        tick();
        chk_st("step_dc", O_DC, 3);
        tick();
        chk_st("step_ex", O_EX, 3);
        STEP = 1'b1;
        tick();
        STEP = 1'b0;
        chk_st("step_wb", O_WB, 3);
        tick();
        chk_st("step_idle", O_IDLE, 4);
        tick();
        chk_st("step_idle2", O_IDLE, 4);

        // 3: stall in EX
        RUN = 1'b1;
        tick(); chk_st("stall_ft", O_FT, 4);
        tick(); chk_st("stall_dc", O_DC, 4);
        tick(); chk_st("stall_ex0", O_EX, 4);
        STALL = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk_st($sformatf("stall_ex%0d", k), O_EX, 4);
        end
        STALL = 1'b0;
        tick(); chk_st("stall_wb", O_WB, 4);
        RUN = 1'b0;
        tick(); chk_st("stall_idle", O_IDLE, 5);

        // 4: halt deferred by WB stall, then sticky until reset
        RUN = 1'b1;
        tick(); chk_st("halt_ft", O_FT, 5);
        tick(); chk_st("halt_dc", O_DC, 5);
        tick(); chk_st("halt_ex", O_EX, 5);
        tick(); chk_st("halt_wb", O_WB, 5);
        STALL = 1'b1;
        HALT_IN = 1'b1;
        tick(); chk_st("halt_wbs1", O_WB, 5);
        tick(); chk_st("halt_wbs2", O_WB, 5);
        STALL = 1'b0;
        tick(); chk_st("halt_enter", O_HALT, 6);
        HALT_IN = 1'b0;
        STEP = 1'b1;
        tick(); chk_st("halt_step", O_HALT, 6);
        STEP = 1'b0;
        STALL = 1'b1;
        tick(); chk_st("halt_run", O_HALT, 6);
        STALL = 1'b0;
        RUN = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_st("halt_rst", O_IDLE, 0);

        // 5: 4-bit counter wrap over 17 instructions
        RUN = 1'b1;
        tick();
        chk("wrap_ft0", 32'(obs4), 32'(O_FT));
        for (int i = 1; i <= 17; i++) begin
            repeat (4) tick();
            chk($sformatf("wrap_cnt4_%0d", i), 32'(cnt4), i % 16);
            chk_st($sformatf("wrap_main_%0d", i), O_FT, i);
        end

        // 6: reset during DC abandons the instruction
        tick();
        chk_st("rst_dc_pre", O_DC, 17);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_st("rst_dc", O_IDLE, 0);
        chk("rst_dc_cnt4", 32'(cnt4), 0);
        RUN = 1'b0;
        tick(); chk_st("rst_idle", O_IDLE, 0);
        RUN = 1'b1;
        tick(); chk_st("rst_restart", O_FT, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
